uart_alu_cmd_if: RTL and testbench

Parametrised command decoder between the UART receiver/transmitter and the ALU. It assembles multi-byte operands A and B and a one-byte opcode from framed command bytes. On request it returns the ALU result as a sequence of UART bytes. It generalises the single-byte operand interface to operand widths that are any multiple of the UART data width, and adds error reporting and an optional receive timeout.

---
 rtl/uart_alu_cmd_if_if.sv | 52 +++++
 rtl/uart_alu_cmd_if.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_alu_cmd_if.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_cmd_if_if.sv
// -----------------------------------------------------------------------------
// uart_alu_cmd_if_if
//
// Bundle of the signals between the UART command decoder and its
// surroundings: UART receiver, UART transmitter and ALU.
//
// Parameters:
//   DBIT - UART data width in bits
//   W    - ALU operand/result width (a multiple of DBIT)
//
// Members (named from the decoder's point of view):
//   i_rx_data  [DBIT] received byte, valid while i_rx_valid is high
//   i_rx_valid        one-cycle strobe marking a received byte
//   i_result   [W]    ALU result, combinational from o_A/o_B/o_op
//   i_tx_done         one-cycle strobe, transmitter finished current byte
//   o_A, o_B   [W]    registered operands
//   o_op       [DBIT] registered opcode
//   o_tx_data  [DBIT] byte to transmit
//   o_tx_start        one-cycle strobe starting a transmission
//   o_busy            decoder is not idle
//   o_err             one-cycle protocol error pulse
//
// Modports:
//   slave  - the decoder (uart_alu_cmd_if)
//   master - the environment driving the decoder
// -----------------------------------------------------------------------------
interface uart_alu_cmd_if_if #(
    parameter int DBIT = 8,
    parameter int W    = 16
);
    logic [DBIT-1:0] i_rx_data;
    logic            i_rx_valid;
    logic [W-1:0]    i_result;
    logic            i_tx_done;
    logic [W-1:0]    o_A;
    logic [W-1:0]    o_B;
    logic [DBIT-1:0] o_op;
    logic [DBIT-1:0] o_tx_data;
    logic            o_tx_start;
    logic            o_busy;
    logic            o_err;

    modport slave (
        input  i_rx_data, i_rx_valid, i_result, i_tx_done,
        output o_A, o_B, o_op, o_tx_data, o_tx_start, o_busy, o_err
    );

    modport master (
        output i_rx_data, i_rx_valid, i_result, i_tx_done,
        input  o_A, o_B, o_op, o_tx_data, o_tx_start, o_busy, o_err
    );
endinterface

// File: rtl/uart_alu_cmd_if.sv
// -----------------------------------------------------------------------------
// uart_alu_cmd_if
//
// Command decoder between a UART receiver/transmitter and an ALU.
// - Command bytes select what the following bytes load: operand A or B
//   (NB = W/DBIT bytes each, least significant byte first) or the opcode
//   (one byte).
// - A result request sends the ALU result back as NB bytes, least
//   significant byte first. If any of A, B or OP has never been loaded,
//   a single NAK byte is sent instead.
// - Unknown commands and bytes that arrive while a result is being sent
//   raise a one-cycle o_err pulse. Bytes arriving during a transmission
//   are dropped.
//
// Ports:
//   clk - system clock
//   rst - synchronous, active-low reset
//   bus - uart_alu_cmd_if_if.slave (rx byte/strobe, ALU result, tx done in;
//         operands, opcode, tx byte/start, busy, error out)
//
// Build option:
//   UART_ALU_TIMEOUT_EN - when defined, an operand/opcode load that sees no
//   byte for TIMEOUT cycles is abandoned with an o_err pulse; the previously
//   committed operands, opcode and valid flags are kept.
// -----------------------------------------------------------------------------
module uart_alu_cmd_if #(
    parameter int              DBIT    = 8,
    parameter int              W       = 16,
    parameter logic [DBIT-1:0] CMD_A   = 8'h01,
    parameter logic [DBIT-1:0] CMD_B   = 8'h02,
    parameter logic [DBIT-1:0] CMD_OP  = 8'h03,
    parameter logic [DBIT-1:0] CMD_R   = 8'h04,
    parameter logic [DBIT-1:0] NAK     = 8'hFF,
    parameter int              TIMEOUT = 1000
) (
    input logic             clk,
    input logic             rst,
    uart_alu_cmd_if_if.slave bus
);
    localparam int NB  = W / DBIT;
    // Byte index inside an operand; kept at least one bit wide for NB = 1.
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    // Remaining bytes to transmit, must be able to hold NB itself.
    localparam int TCW = $clog2(NB + 1);

    // Parameter sanity, caught at elaboration.
    if ((W % DBIT) != 0 || W < DBIT) begin : g_bad_width
        $error("uart_alu_cmd_if: W must be a non-zero multiple of DBIT");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_alu_cmd_if: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_LOAD_OP,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_t;

    state_t          state_reg;
    logic [BCW-1:0]  byte_cnt_reg;
    logic [TCW-1:0]  tx_cnt_reg;
    logic [W-1:0]    shift_reg;
    logic [W-1:0]    staging_reg;
    logic [W-1:0]    staging_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [DBIT-1:0] op_reg;
    logic [DBIT-1:0] tx_data_reg;
    logic            tx_start_reg;
    logic            err_reg;
    logic            valid_a_reg;
    logic            valid_b_reg;
    logic            valid_op_reg;

`ifdef UART_ALU_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT);
    logic [TOW-1:0]  to_cnt_reg;
`endif

    // Staging register with the current rx byte dropped into the lane
    // selected by the byte counter. Committing staging_next (rather than
    // staging_reg) lets the last byte reach o_A/o_B in the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign staging_next[gi*DBIT +: DBIT] =
                (byte_cnt_reg == BCW'(gi)) ? bus.i_rx_data
                                           : staging_reg[gi*DBIT +: DBIT];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            tx_cnt_reg   <= '0;
            shift_reg    <= '0;
            staging_reg  <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            err_reg      <= 1'b0;
            valid_a_reg  <= 1'b0;
            valid_b_reg  <= 1'b0;
            valid_op_reg <= 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
            to_cnt_reg   <= '0;
`endif
        end else begin
            // Strobes are single-cycle by default.
            tx_start_reg <= 1'b0;
            err_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_rx_valid) begin
                        if (bus.i_rx_data == CMD_A) begin
                            state_reg    <= ST_LOAD_A;
                            byte_cnt_reg <= '0;
                        end else if (bus.i_rx_data == CMD_B) begin
                            state_reg    <= ST_LOAD_B;
                            byte_cnt_reg <= '0;
                        end else if (bus.i_rx_data == CMD_OP) begin
                            state_reg    <= ST_LOAD_OP;
                        end else if (bus.i_rx_data == CMD_R) begin
                            if (valid_a_reg && valid_b_reg && valid_op_reg) begin
                                // Snapshot now so later ALU input changes
                                // cannot corrupt bytes already queued.
                                shift_reg  <= bus.i_result;
                                tx_cnt_reg <= TCW'(NB);
                            end else begin
                                shift_reg  <= W'(NAK);
                                tx_cnt_reg <= TCW'(1);
                            end
                            state_reg <= ST_TX_LOAD;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end

                ST_LOAD_A, ST_LOAD_B: begin
                    if (bus.i_rx_valid) begin
                        staging_reg <= staging_next;
                        if (byte_cnt_reg == BCW'(NB - 1)) begin
                            if (state_reg == ST_LOAD_A) begin
                                a_reg       <= staging_next;
                                valid_a_reg <= 1'b1;
                            end else begin
                                b_reg       <= staging_next;
                                valid_b_reg <= 1'b1;
                            end
                            state_reg <= ST_IDLE;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_LOAD_OP: begin
                    if (bus.i_rx_valid) begin
                        op_reg       <= bus.i_rx_data;
                        valid_op_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end

                ST_TX_LOAD: begin
                    tx_data_reg  <= shift_reg[DBIT-1:0];
                    tx_start_reg <= 1'b1;
                    state_reg    <= ST_TX_WAIT;
                    if (bus.i_rx_valid) begin
                        err_reg <= 1'b1;
                    end
                end

                ST_TX_WAIT: begin
                    // Overrun is flagged but a coincident tx_done still
                    // advances the transmission.
                    if (bus.i_rx_valid) begin
                        err_reg <= 1'b1;
                    end
                    if (bus.i_tx_done) begin
                        tx_cnt_reg <= tx_cnt_reg - 1'b1;
                        if (tx_cnt_reg == TCW'(1)) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            shift_reg <= shift_reg >> DBIT;
                            state_reg <= ST_TX_LOAD;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

`ifdef UART_ALU_TIMEOUT_EN
            // Inter-byte watchdog for the load states. Held at zero
            // elsewhere, so it always starts from zero on command entry.
            // Expiry overrides the case above; no byte arrived this cycle,
            // so no commit can be in flight.
            if (state_reg == ST_LOAD_A || state_reg == ST_LOAD_B ||
                state_reg == ST_LOAD_OP) begin
                if (bus.i_rx_valid) begin
                    to_cnt_reg <= '0;
                end else if (to_cnt_reg == TOW'(TIMEOUT - 1)) begin
                    to_cnt_reg  <= '0;
                    err_reg     <= 1'b1;
                    staging_reg <= '0;
                    state_reg   <= ST_IDLE;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
`endif
        end
    end

    assign bus.o_A        = a_reg;
    assign bus.o_B        = b_reg;
    assign bus.o_op       = op_reg;
    assign bus.o_tx_data  = tx_data_reg;
    assign bus.o_tx_start = tx_start_reg;
    assign bus.o_err      = err_reg;
    assign bus.o_busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_alu_cmd_if.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_cmd_if
//
// Directed bench for uart_alu_cmd_if (DBIT = 8, W = 16). Expected transmit
// bytes are queued when a result request is driven; a monitor records every
// byte the decoder starts, and the two lists are compared after each
// transmission. Cycle-exact checks cover decode, commit, transmit latency,
// error pulses, timeout and reset.
// -----------------------------------------------------------------------------
module tb_uart_alu_cmd_if;
    localparam int DBIT    = 8;
    localparam int W       = 16;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_alu_cmd_if_if #(.DBIT(DBIT), .W(W)) bus ();

    uart_alu_cmd_if #(
        .DBIT   (DBIT),
        .W      (W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DBIT-1:0] exp_q[$];
    logic [DBIT-1:0] obs_q[$];
    int              obs_rd = 0;

    // Record every byte the decoder launches.
    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) begin
            obs_q.push_back(bus.o_tx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DBIT-1:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
    endtask

    task automatic pulse_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    // Compare recorded bytes since the last call against the expected queue.
    task automatic sb_check(input string tag);
        logic [DBIT-1:0] e;
        check({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                check({tag, "_byte"}, 32'(obs_q[obs_rd]), 32'(e));
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int n0;

        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_result   = '0;
        bus.i_tx_done  = 1'b0;

        // ---- reset ----
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_A",     32'(bus.o_A), 32'h0);
        check("rst_B",     32'(bus.o_B), 32'h0);
        check("rst_op",    32'(bus.o_op), 32'h0);
        check("rst_txd",   32'(bus.o_tx_data), 32'h0);
        check("rst_start", 32'(bus.o_tx_start), 32'h0);
        check("rst_busy",  32'(bus.o_busy), 32'h0);
        check("rst_err",   32'(bus.o_err), 32'h0);

        // ---- result request with nothing loaded -> NAK ----
        exp_q.push_back(8'hFF);
        send_byte(8'h04);
        check("nak_busy",   32'(bus.o_busy), 32'h1);
        check("nak_start0", 32'(bus.o_tx_start), 32'h0);
        tick();
        check("nak_start1", 32'(bus.o_tx_start), 32'h1);
        check("nak_data",   32'(bus.o_tx_data), 32'hFF);
        tick();
        check("nak_start2", 32'(bus.o_tx_start), 32'h0);
        check("nak_hold",   32'(bus.o_tx_data), 32'hFF);
        tick();
        pulse_done();
        check("nak_idle",   32'(bus.o_busy), 32'h0);
        sb_check("nak");

        // ---- load A = 0x1234, LSB first ----
        send_byte(8'h01);
        check("a_cmd_busy", 32'(bus.o_busy), 32'h1);
        send_byte(8'h34);
        check("a_partial",  32'(bus.o_A), 32'h0);
        send_byte(8'h12);
        check("a_commit",   32'(bus.o_A), 32'h1234);
        check("a_idle",     32'(bus.o_busy), 32'h0);

        // ---- load B = 0x0001, OP = 0x20 ----
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h00);
        check("b_commit", 32'(bus.o_B), 32'h0001);
        send_byte(8'h03);
        send_byte(8'h20);
        check("op_commit", 32'(bus.o_op), 32'h20);
        check("op_idle",   32'(bus.o_busy), 32'h0);

        // ---- two-byte result, snapshot taken at request ----
        bus.i_result = 16'h1235;
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h12);
        send_byte(8'h04);
        bus.i_result = 16'hBEEF;
        tick();
        check("r0_start", 32'(bus.o_tx_start), 32'h1);
        check("r0_data",  32'(bus.o_tx_data), 32'h35);
        tick();
        tick();
        pulse_done();
        check("r1_gap",   32'(bus.o_tx_start), 32'h0);
        check("r1_busy",  32'(bus.o_busy), 32'h1);
        tick();
        check("r1_start", 32'(bus.o_tx_start), 32'h1);
        check("r1_data",  32'(bus.o_tx_data), 32'h12);
        tick();
        pulse_done();
        check("r_idle",   32'(bus.o_busy), 32'h0);
        sb_check("res");

        // ---- unknown command in IDLE ----
        send_byte(8'h07);
        check("bad_err",  32'(bus.o_err), 32'h1);
        check("bad_busy", 32'(bus.o_busy), 32'h0);
        tick();
        check("bad_err_end", 32'(bus.o_err), 32'h0);

        // ---- overrun during transmission ----
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        send_byte(8'h04);
        tick();
        send_byte(8'h01);
        check("ovr_err",  32'(bus.o_err), 32'h1);
        check("ovr_busy", 32'(bus.o_busy), 32'h1);
        tick();
        check("ovr_err_end", 32'(bus.o_err), 32'h0);
        pulse_done();
        tick();
        check("ovr_data", 32'(bus.o_tx_data), 32'hBE);
        tick();
        pulse_done();
        check("ovr_idle", 32'(bus.o_busy), 32'h0);
        check("ovr_A",    32'(bus.o_A), 32'h1234);
        sb_check("ovr");

        // ---- stalled operand load ----
        send_byte(8'h01);
        send_byte(8'hAA);
        errs = 0;
        for (int i = 0; i < TIMEOUT + 5; i++) begin
            if (bus.o_err === 1'b1) errs++;
            tick();
        end
`ifdef UART_ALU_TIMEOUT_EN
        check("to_err_count", 32'(errs), 32'd1);
        check("to_A_kept",    32'(bus.o_A), 32'h1234);
        check("to_idle",      32'(bus.o_busy), 32'h0);
`else
        check("nto_err_count", 32'(errs), 32'd0);
        check("nto_busy",      32'(bus.o_busy), 32'h1);
        send_byte(8'h55);
        check("nto_A",         32'(bus.o_A), 32'h55AA);
        check("nto_idle",      32'(bus.o_busy), 32'h0);
`endif

        // ---- reset between two result bytes ----
        exp_q.push_back(8'hEF);
        send_byte(8'h04);
        tick();
        tick();
        pulse_done();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n0 = obs_q.size();
        check("mrst_A",     32'(bus.o_A), 32'h0);
        check("mrst_B",     32'(bus.o_B), 32'h0);
        check("mrst_op",    32'(bus.o_op), 32'h0);
        check("mrst_txd",   32'(bus.o_tx_data), 32'h0);
        check("mrst_start", 32'(bus.o_tx_start), 32'h0);
        check("mrst_busy",  32'(bus.o_busy), 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("mrst_no_start", 32'(obs_q.size()), 32'(n0));
        sb_check("mrst");

        // Flags cleared: a request must now be refused.
        exp_q.push_back(8'hFF);
        send_byte(8'h04);
        tick();
        check("mrst_nak", 32'(bus.o_tx_data), 32'hFF);
        tick();
        pulse_done();
        check("mrst_nak_idle", 32'(bus.o_busy), 32'h0);
        sb_check("mrst_nak");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
